ahb2_sram_slave: RTL and testbench
==================================

# ahb2_sram_slave

AHB2 single-port SRAM slave with a configurable wait-state count and two-cycle ERROR response. Sits directly downstream of the single-master AHB2 bus and attaches to its slave-side `AHB2_SLV_INTF`. It consumes the address/control/write-data phase and returns `hrdata`, `hresp` and `hreadyo`. It is the default memory target for AHB2 VIP benches.

## Interface
- `ADDR_WIDTH`, 32: `haddr` width.
- `DATA_WIDTH`, 32: `hwdata`/`hrdata` width. Fixed at 32 for this revision.
- `MEM_DEPTH`, 1024: number of 32-bit words.
- `BASE_ADDR`, 32'h0: byte address of word 0.
- `WAIT_CYCLES`, 0: `hreadyo`-low cycles inserted in every OKAY data phase. Range 0..15.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `s_if` `AHB2_SLV_INTF.slave` –: AHB2 slave port.
  - Inputs: `hsel`, `haddr`, `htrans[1:0]`, `hwrite`, `hsize[2:0]`, `hburst[2:0]`, `hprot[3:0]`, `hwdata`, `hreadyi`.
  - Outputs: `hreadyo`, `hrdata`, `hresp[1:0]`.

## Operation
- **Transfer accept:** an address phase is accepted on a rising edge where `hsel && hreadyi && htrans[1]` (NONSEQ or SEQ).
  - IDLE and BUSY are not accepted. They produce a zero-wait OKAY data phase.
- **Registered on accept:** word index, byte lanes, `hwrite`, and an error flag.
- **Error conditions:** any of the following gives ERROR:
  - `haddr - BASE_ADDR >= MEM_DEPTH*4`,
  - `hsize > 2`,
  - misalignment (`hsize==1 && haddr[0]`, or `hsize==2 && haddr[1:0]!=0`).
- **Byte lanes:** little-endian.
  - `hsize` 0 → lane `haddr[1:0]`.
  - `hsize` 1 → lanes {1,0} or {3,2} per `haddr[1]`.
  - `hsize` 2 → all four lanes.
- `hburst` and `hprot` are ignored. Every beat carries its own address.
- **FSM (states in `ahb2_pkg`):**
  - `ST_IDLE`: `hreadyo=1`, `hresp=OKAY`.
    - Accept with error → `ST_ERR1`.
    - Accept with `WAIT_CYCLES>0` → `ST_WAIT`, counter loaded with `WAIT_CYCLES-1`.
    - Otherwise stay.
  - `ST_WAIT`: `hreadyo=0`, `hresp=OKAY`. Counter decrements each cycle. At 0 → `ST_IDLE`, whose cycle is the completing (`hreadyo=1`) data-phase cycle.
  - `ST_ERR1`: `hreadyo=0`, `hresp=ERROR` → `ST_ERR2`.
  - `ST_ERR2`: `hreadyo=1`, `hresp=ERROR`. A new address phase may be accepted here. Next state follows the `ST_IDLE` rules.
- **Writes:** enabled bytes of `hwdata` are written on the edge that ends the data-phase cycle with `hreadyo=1`. Errored writes never modify memory.
- **Reads:** the array is read synchronously using `haddr` at the accepting edge. `hrdata` holds that word through the data phase. Unselected lanes return real memory contents.
- **Read-after-write forwarding:** if a read's address phase coincides with the completing data phase of a write to the same word, `hrdata` returns old word bytes merged with the written bytes on the written lanes.
- **Errored reads:** `hrdata = 0`.
- **Master behaviour during errors:** if the master drops `htrans` to IDLE during `ST_ERR1`, `ST_ERR2` is still completed.
- **Mid-operation reset:** FSM → `ST_IDLE`, counter cleared, pending write discarded. Memory contents are not reset.

## Timing
- **Reset values:** `hreadyo=1`, `hresp=OKAY(2'b00)`, `hrdata=0`, state `ST_IDLE`, wait counter 0.
- **Zero-wait OKAY:** address phase in cycle N, `hreadyo=1` with valid `hrdata` in N+1. This sustains back-to-back transfers at one per cycle.
- **With `WAIT_CYCLES=k`:** `hreadyo` is low in N+1..N+k and high in N+k+1.
- **ERROR:** always exactly two cycles (N+1 low/ERROR, N+2 high/ERROR), regardless of `WAIT_CYCLES`.
- `hreadyo`, `hresp` and `hrdata` are driven from registers. There is no combinational path from `haddr` or `htrans` to any output.

## Structure
- **Shared package `ahb2_pkg`:**
  - `htrans_t` (IDLE/BUSY/NONSEQ/SEQ),
  - `hresp_t` (OKAY/ERROR/RETRY/SPLIT),
  - `hsize_t`,
  - `ahb2_slv_state_t`,
  - a function `byte_lanes(hsize, haddr[1:0])`.
- **Sub-module `ahb2_sram_mem`:**
  - one write port with 4-bit byte enable and one synchronous read port, same clock.
  - `MEM_DEPTH` words, no reset.
  - Forwarding stays in the top level.

## Test plan
- **Word write then read, `WAIT_CYCLES=0`:** NONSEQ write 32'hDEADBEEF @0x10, then NONSEQ read @0x10 in the next cycle. Expected: read data phase `hreadyo=1`, `hrdata=32'hDEADBEEF` (forwarded), `hresp=OKAY`.
- **Byte write:** byte write 8'hA5 @0x13 over word 32'h00000000, then word read @0x10. Expected: `hrdata=32'hA5000000`.
- **Wait states, `WAIT_CYCLES=3`:** read @0x0. Expected: `hreadyo` low for exactly 3 cycles, then high with data. A 4-beat INCR burst takes 16 cycles.
- **Out-of-range write (`MEM_DEPTH=1024`):** write @0x1000. Expected: `hreadyo`/`hresp` sequence 0/ERROR then 1/ERROR, and memory unchanged. Also misaligned halfword @0x1 → same ERROR sequence.
- **Reset mid-operation:** assert `rst_n=0` during `ST_WAIT` of a write. Expected: next cycle `hreadyo=1`, `hresp=OKAY`, `hrdata=0`, and the target word is unchanged.
- **IDLE/BUSY and deselect:** `htrans=IDLE`/`BUSY` with `hsel=1`, and NONSEQ with `hsel=0`. Expected: zero-wait OKAY and no memory write.

Source files
------------

// File: rtl/ahb2_pkg.sv
// ahb2_pkg: shared AHB2 encodings, slave FSM states and byte-lane decode
package ahb2_pkg;
    typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
    typedef enum logic [1:0] {HRESP_OKAY, HRESP_ERROR, HRESP_RETRY, HRESP_SPLIT} hresp_t;
    typedef enum logic [2:0] {
        HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD,
        HSIZE_4WORD, HSIZE_8WORD, HSIZE_16WORD, HSIZE_32WORD
    } hsize_t;
    typedef logic [1:0] ahb2_slv_state_t;
    localparam ahb2_slv_state_t ST_IDLE = 2'd0;
    localparam ahb2_slv_state_t ST_WAIT = 2'd1;
    localparam ahb2_slv_state_t ST_ERR1 = 2'd2;
    localparam ahb2_slv_state_t ST_ERR2 = 2'd3;

    function automatic logic [3:0] byte_lanes(input logic [2:0] hsize, input logic [1:0] a);
        return hsize == 3'd0 ? 4'b0001 << a : hsize == 3'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/ahb2_slv_intf.sv
// AHB2_SLV_INTF: slave-side AHB2 signal bundle
interface AHB2_SLV_INTF #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hreadyi;
    logic                  hreadyo;
    logic [DATA_WIDTH-1:0] hrdata;
    logic [1:0]            hresp;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
        output hreadyo, hrdata, hresp
    );
endinterface

// File: rtl/ahb2_sram_mem.sv
// ahb2_sram_mem: word array with byte-enabled write port and synchronous read port
module ahb2_sram_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ahb2_sram_slave.sv
// ahb2_sram_slave: AHB2 SRAM slave with configurable wait states and two-cycle ERROR response
module ahb2_sram_slave
    import ahb2_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0
) (
    input logic         clk,
    input logic         rst_n,
    AHB2_SLV_INTF.slave s_if
);
    localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

    ahb2_slv_state_t       state_q, state_d;
    logic [3:0]            cnt_q, cnt_d, lanes_q, lanes_a, fwd_be_q;
    logic [IW-1:0]         idx_q, idx_a;
    logic [ADDR_WIDTH-1:0] off;
    logic [DATA_WIDTH-1:0] mem_rd, fwd_data_q, rdata;
    logic                  wr_pend_q, rd_zero_q, ready_q, acc, err_a, we, re, fwd;
    hresp_t                resp_q;
    logic                  unused;

    assign unused  = ^{s_if.hburst, s_if.hprot, s_if.htrans[0]};
    assign off     = s_if.haddr - BASE_ADDR;
    assign idx_a   = off[IW+1:2];
    assign lanes_a = byte_lanes(s_if.hsize, s_if.haddr[1:0]);
    assign err_a   = off >= ADDR_WIDTH'(MEM_DEPTH * 4) || s_if.hsize > 3'd2 ||
                     (s_if.hsize == 3'd1 && s_if.haddr[0]) ||
                     (s_if.hsize == 3'd2 && s_if.haddr[1:0] != 2'b00);
    assign acc     = ready_q && s_if.hsel && s_if.hreadyi && s_if.htrans[1];
    // The pending write lands on the cycle the data phase completes, i.e. back in ST_IDLE
    assign we      = rst_n && wr_pend_q && state_q == ST_IDLE;
    assign re      = acc && !err_a && !s_if.hwrite;
    assign fwd     = re && we && idx_a == idx_q;

    ahb2_sram_mem #(.DEPTH(MEM_DEPTH), .AW(IW)) u_mem (
        .clk  (clk),
        .we   (we),
        .be   (lanes_q),
        .waddr(idx_q),
        .wdata(s_if.hwdata),
        .re   (re),
        .raddr(idx_a),
        .rdata(mem_rd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_WAIT) begin
            state_d = cnt_q == 4'd0 ? ST_IDLE : ST_WAIT;
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else begin
            state_d = !acc ? ST_IDLE : err_a ? ST_ERR1 : WAIT_CYCLES > 0 ? ST_WAIT : ST_IDLE;
            cnt_d   = acc && !err_a && WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_pend_q <= 1'b0;
            rd_zero_q <= 1'b1;
            ready_q   <= 1'b1;
            resp_q    <= HRESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= state_d == ST_IDLE || state_d == ST_ERR2;
            resp_q    <= state_d == ST_ERR1 || state_d == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
            wr_pend_q <= acc ? s_if.hwrite && !err_a : wr_pend_q && !we;
            if (acc) rd_zero_q <= err_a;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            idx_q      <= idx_a;
            lanes_q    <= lanes_a;
            fwd_be_q   <= fwd ? lanes_q : 4'b0000;
            fwd_data_q <= s_if.hwdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++)
            rdata[8*i +: 8] = rd_zero_q ? 8'h00 : fwd_be_q[i] ? fwd_data_q[8*i +: 8] : mem_rd[8*i +: 8];
    end

    assign s_if.hrdata  = rdata;
    assign s_if.hreadyo = ready_q;
    assign s_if.hresp   = resp_q;
endmodule

// File: tb/tb_ahb2_sram_slave.sv
// tb_ahb2_sram_slave: directed checks of a zero-wait and a three-wait SRAM slave
module tb_ahb2_sram_slave;
    import ahb2_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, s0 = 1'b0, s3 = 1'b0, hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] haddr = '0, hwdata = '0, first_rd;
    int          n_checks = 0, n_fail = 0, nb, cyc;

    always #5 clk = ~clk;

    AHB2_SLV_INTF i0();
    AHB2_SLV_INTF i3();

    assign i0.hsel = s0;       assign i3.hsel = s3;
    assign i0.haddr = haddr;   assign i3.haddr = haddr;
    assign i0.htrans = htrans; assign i3.htrans = htrans;
    assign i0.hwrite = hwrite; assign i3.hwrite = hwrite;
    assign i0.hsize = hsize;   assign i3.hsize = hsize;
    assign i0.hburst = 3'd1;   assign i3.hburst = 3'd1;
    assign i0.hprot = 4'd0;    assign i3.hprot = 4'd0;
    assign i0.hwdata = hwdata; assign i3.hwdata = hwdata;
    assign i0.hreadyi = i0.hreadyo;
    assign i3.hreadyi = i3.hreadyo;

    ahb2_sram_slave #(.WAIT_CYCLES(0)) d0 (.clk(clk), .rst_n(rst_n), .s_if(i0.slave));
    ahb2_sram_slave #(.WAIT_CYCLES(3)) d3 (.clk(clk), .rst_n(rst_n), .s_if(i3.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ap(input logic a0, input logic a3, input logic [1:0] tr, input logic w,
                      input logic [2:0] sz, input logic [31:0] a);
        s0 = a0; s3 = a3; htrans = tr; hwrite = w; hsize = sz; haddr = a;
    endtask

    task automatic idle();
        ap(1'b0, 1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, sz, a); step();
        hwdata = d; idle(); step();
    endtask

    task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a); step(); idle();
        check(tag, i0.hrdata, exp);
        check({tag, "_rdy"}, 32'(i0.hreadyo), 1);
        step();
    endtask

    task automatic wait3();
        for (int n = 0; n < 20 && !i3.hreadyo; n++) step();
    endtask

    task automatic wr3(input logic [31:0] a, input logic [31:0] d);
        ap(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, a); step();
        hwdata = d; idle(); wait3();
        check("wr3_rdy", 32'(i3.hreadyo), 1);
        step();
    endtask

    task automatic rd3(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ap(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a); step(); idle(); wait3();
        check(tag, i3.hrdata, exp);
        check({tag, "_rdy"}, 32'(i3.hreadyo), 1);
        step();
    endtask

    task automatic err_seq(input string tag);
        check({tag, "_e1_rdy"}, 32'(i0.hreadyo), 0);
        check({tag, "_e1_resp"}, 32'(i0.hresp), 1);
        step();
        check({tag, "_e2_rdy"}, 32'(i0.hreadyo), 1);
        check({tag, "_e2_resp"}, 32'(i0.hresp), 1);
        step();
        check({tag, "_ok_resp"}, 32'(i0.hresp), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(); step(); step(); step();
        check("rst_rdy0", 32'(i0.hreadyo), 1);
        check("rst_resp0", 32'(i0.hresp), 0);
        check("rst_data0", i0.hrdata, 0);
        check("rst_rdy3", 32'(i3.hreadyo), 1);
        check("rst_resp3", 32'(i3.hresp), 0);
        check("rst_data3", i3.hrdata, 0);
        rst_n = 1'b1; step();

        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10); step();
        hwdata = 32'hDEADBEEF;
        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        check("wr_rdy", 32'(i0.hreadyo), 1);
        step(); idle();
        check("fwd_data", i0.hrdata, 32'hDEADBEEF);
        check("fwd_rdy", 32'(i0.hreadyo), 1);
        check("fwd_resp", 32'(i0.hresp), 0);
        step();
        rd0("rd_10", 32'h10, 32'hDEADBEEF);

        wr0(32'h10, HSIZE_WORD, 32'h0);
        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13); step();
        hwdata = 32'hA5FFFFFF;
        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        step(); idle();
        check("byte_fwd", i0.hrdata, 32'hA5000000);
        step();
        rd0("byte_rd", 32'h10, 32'hA5000000);
        wr0(32'h12, HSIZE_HALF, 32'hBEEF1234);
        rd0("half_rd", 32'h10, 32'hBEEF0000);
        wr0(32'h11, HSIZE_BYTE, 32'h1234C378);
        rd0("byte1_rd", 32'h10, 32'hBEEFC300);
        wr0(32'h0, HSIZE_WORD, 32'hCAFEF00D);

        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h1000); step();
        hwdata = 32'hFFFFFFFF; idle();
        err_seq("oor");
        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h1); step();
        hwdata = 32'h0; idle();
        err_seq("misal");
        rd0("err_mem", 32'h0, 32'hCAFEF00D);

        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h0); step();
        check("bigsz_e1_rdy", 32'(i0.hreadyo), 0);
        check("bigsz_e1_data", i0.hrdata, 0);
        ap(1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0); step();
        check("bigsz_e2_resp", 32'(i0.hresp), 1);
        check("bigsz_e2_data", i0.hrdata, 0);
        step(); idle();
        check("after_err_resp", 32'(i0.hresp), 0);
        check("after_err_data", i0.hrdata, 32'hCAFEF00D);
        step();

        ap(1'b1, 1'b0, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h0); step();
        hwdata = 32'h0;
        check("idle_rdy", 32'(i0.hreadyo), 1);
        ap(1'b1, 1'b0, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h0); step();
        check("busy_rdy", 32'(i0.hreadyo), 1);
        check("busy_resp", 32'(i0.hresp), 0);
        ap(1'b0, 1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0); step();
        check("desel_rdy", 32'(i0.hreadyo), 1);
        idle(); step();
        rd0("nowr_rd", 32'h0, 32'hCAFEF00D);

        ap(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0); step();
        hwdata = 32'h12345678; idle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wwait%0d", k), 32'(i3.hreadyo), 0);
            step();
        end
        check("wdone_rdy", 32'(i3.hreadyo), 1);
        ap(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0); step(); idle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rwait%0d", k), 32'(i3.hreadyo), 0);
            step();
        end
        check("rdone_rdy", 32'(i3.hreadyo), 1);
        check("rdone_data", i3.hrdata, 32'h12345678);
        step();
        rd3("rd3_0", 32'h0, 32'h12345678);

        ap(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0); step();
        nb = 0; cyc = 0; first_rd = '0;
        while (nb < 4 && cyc < 40) begin
            cyc++;
            if (i3.hreadyo) begin
                if (nb == 0) first_rd = i3.hrdata;
                nb++;
                if (nb < 4) ap(1'b0, 1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'(nb * 4));
                else idle();
            end
            step();
        end
        check("burst_cycles", 32'(cyc), 16);
        check("burst_beat0", first_rd, 32'h12345678);

        wr3(32'h4, 32'h55667788);
        ap(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h4); step();
        hwdata = 32'hAAAAAAAA; idle(); step();
        rst_n = 1'b0; step();
        check("mrst_rdy", 32'(i3.hreadyo), 1);
        check("mrst_resp", 32'(i3.hresp), 0);
        check("mrst_data", i3.hrdata, 0);
        rst_n = 1'b1; step();
        rd3("mrst_keep", 32'h4, 32'h55667788);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
